// File: rtl/axi_read_scheduler_pkg.sv
// Definitions shared by the AXI read/write scheduler pair: FSM state encoding,
// AR size/burst constants and a data-width legality helper.
package axi_read_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
    localparam int         AXI_MAX_BEATS      = 256;
    localparam int         AXI_BOUNDARY_BYTES = 4096;

    // ARSIZE code for a beat that fills the whole data bus.
    function automatic logic [2:0] axi_size(input int data_w);
        logic [2:0] sz;
        sz = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if ((8 << b) == data_w) sz = 3'(b);
        end
        return sz;
    endfunction

    function automatic bit data_w_legal(input int data_w);
        return (data_w >= 8) && (data_w <= 1024) && ((data_w & (data_w - 1)) == 0);
    endfunction

endpackage

// File: rtl/axi_read_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after ptr,
// wrapping around, as a one-hot vector.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_read_scheduler.sv
// AXI read scheduler: arbitrates requesters round-robin, then walks the burst
// splitter through AR/R bursts until the owner's transfer completes.
module axi_read_scheduler
    import axi_read_scheduler_pkg::*;
#(
    parameter int  AXI_ADDR_W = 32,
    parameter int  AXI_DATA_W = 32,
    parameter int  LEN_W      = 32,
    parameter int  N_REQ      = 2,
    localparam int OWN_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*AXI_ADDR_W-1:0] req_addr,
    input  logic [N_REQ*LEN_W-1:0]      req_len,
    output logic [N_REQ-1:0]            req_done,
    output logic [AXI_ADDR_W-1:0]       split_address,
    output logic [LEN_W-1:0]            split_length,
    output logic                        split_transfer_start,
    output logic                        split_burst_start,
    input  logic [AXI_ADDR_W-1:0]       split_axaddr,
    input  logic [7:0]                  split_axlen,
    input  logic                        split_last,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    output logic [AXI_ADDR_W-1:0]       m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    input  logic                        m_axi_rlast,
    output logic                        busy,
    output logic [OWN_W-1:0]            owner,
    output logic                        err
);

    if (!data_w_legal(AXI_DATA_W)) begin : g_bad_data_w
        $error("axi_read_scheduler: AXI_DATA_W must be a power of two between 8 and 1024");
    end

    sched_state_t          state;
    sched_state_t          state_nx;
    logic [OWN_W-1:0]      rr_ptr;
    logic [N_REQ-1:0]      grant;
    logic [OWN_W-1:0]      grant_idx;
    logic [AXI_ADDR_W-1:0] addr_arr [N_REQ];
    logic [LEN_W-1:0]      len_arr  [N_REQ];
    logic [AXI_ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]      sel_len;
    logic [7:0]            beat_cnt;
    logic                  last_q;
    logic                  grant_fire;
    logic                  ar_fire;
    logic                  r_fire;
    logic                  final_beat;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*AXI_ADDR_W +: AXI_ADDR_W];
        assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
    end

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (OWN_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) grant_idx = OWN_W'(k);
        end
    end

    assign sel_addr   = addr_arr[grant_idx];
    assign sel_len    = len_arr[grant_idx];
    assign grant_fire = (state == ST_IDLE) && (|grant);
    assign ar_fire    = (state == ST_ADDR) && m_axi_arready;
    assign r_fire     = (state == ST_DATA) && m_axi_rvalid;
    assign final_beat = r_fire && (beat_cnt == 8'd0);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // A zero-length grant skips the splitter and AXI entirely.
    always_comb begin
        state_nx             = state;
        req_ready            = '0;
        split_transfer_start = 1'b0;
        split_burst_start    = 1'b0;
        m_axi_arvalid        = 1'b0;
        m_axi_araddr         = '0;
        m_axi_arlen          = '0;
        m_axi_rready         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    req_ready = grant;
                    state_nx  = (sel_len == '0) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                split_transfer_start = 1'b1;
                state_nx             = ST_ADDR;
            end
            ST_ADDR: begin
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = split_axaddr;
                m_axi_arlen   = split_axlen;
                if (m_axi_arready) begin
                    split_burst_start = 1'b1;
                    state_nx          = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_rready = 1'b1;
                if (final_beat) state_nx = last_q ? ST_DONE : ST_ADDR;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // The burst position is tracked by beat_cnt alone; rlast only feeds the error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            owner         <= '0;
            split_address <= '0;
            split_length  <= '0;
            beat_cnt      <= '0;
            last_q        <= 1'b0;
            err           <= 1'b0;
            req_done      <= '0;
        end else begin
            req_done <= '0;
            if (grant_fire) begin
                split_address <= sel_addr;
                split_length  <= sel_len;
                owner         <= grant_idx;
                rr_ptr        <= OWN_W'((int'(grant_idx) + 1) % N_REQ);
            end
            if (ar_fire) begin
                last_q   <= split_last;
                beat_cnt <= split_axlen;
            end
            if (r_fire) begin
                if (beat_cnt != 8'd0) beat_cnt <= beat_cnt - 8'd1;
                if (m_axi_rlast != (beat_cnt == 8'd0)) err <= 1'b1;
            end
            if (state == ST_DONE) req_done <= N_REQ'(1) << owner;
        end
    end

endmodule

// File: tb/tb_axi_read_scheduler.sv
// Directed bench for axi_read_scheduler with a behavioural burst splitter and
// AXI read slave driven cycle by cycle from the stimulus process.
module tb_axi_read_scheduler;

    localparam int AW = 32;
    localparam int LW = 32;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;
    logic [NR-1:0]    req_done;
    logic [AW-1:0]    split_address;
    logic [LW-1:0]    split_length;
    logic             split_transfer_start;
    logic             split_burst_start;
    logic [AW-1:0]    split_axaddr;
    logic [7:0]       split_axlen;
    logic             split_last;
    logic             m_axi_arvalid;
    logic             m_axi_arready;
    logic [AW-1:0]    m_axi_araddr;
    logic [7:0]       m_axi_arlen;
    logic             m_axi_rvalid;
    logic             m_axi_rready;
    logic             m_axi_rlast;
    logic             busy;
    logic [0:0]       owner;
    logic             err;

    always #5 clk = ~clk;

    axi_read_scheduler #(
        .AXI_ADDR_W (AW),
        .AXI_DATA_W (32),
        .LEN_W      (LW),
        .N_REQ      (NR)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_addr             (req_addr),
        .req_len              (req_len),
        .req_done             (req_done),
        .split_address        (split_address),
        .split_length         (split_length),
        .split_transfer_start (split_transfer_start),
        .split_burst_start    (split_burst_start),
        .split_axaddr         (split_axaddr),
        .split_axlen          (split_axlen),
        .split_last           (split_last),
        .m_axi_arvalid        (m_axi_arvalid),
        .m_axi_arready        (m_axi_arready),
        .m_axi_araddr         (m_axi_araddr),
        .m_axi_arlen          (m_axi_arlen),
        .m_axi_rvalid         (m_axi_rvalid),
        .m_axi_rready         (m_axi_rready),
        .m_axi_rlast          (m_axi_rlast),
        .busy                 (busy),
        .owner                (owner),
        .err                  (err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [NR-1:0] want_valid = '0;
    logic [NR-1:0] drop_mask = '1;
    int            grant_limit = 0;

    logic [31:0] sp_addr = '0;
    logic [31:0] sp_rem = '0;
    logic        pend_xfer = 1'b0;
    logic        pend_burst = 1'b0;

    int ar_stall_cfg = 0;
    int ar_wait = 0;
    int r_total = 0;
    int r_idx = 0;
    int early_last = -1;

    logic [31:0] ar_addr_log [8];
    logic [7:0]  ar_len_log  [8];
    int          grant_log   [8];
    logic [1:0]  done_log    [8];
    int          done_owner  [8];
    int ar_count, burst_cnt, bad_burst, xfer_cnt, arvalid_cycles, stall_bad;
    int grant_count, grant_cycle, done_count, done_cycle, beat_count, last_beat_idx;
    logic        hold_valid = 1'b0;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] chunk_of(input logic [31:0] a, input logic [31:0] rem);
        logic [31:0] to4k;
        logic [31:0] c;
        to4k = 32'h1000 - {20'd0, a[11:0]};
        c = rem;
        if (c > to4k) c = to4k;
        if (c > 32'd1024) c = 32'd1024;
        return c;
    endfunction

    task automatic clear_logs();
        ar_count = 0; burst_cnt = 0; bad_burst = 0; xfer_cnt = 0;
        arvalid_cycles = 0; stall_bad = 0; grant_count = 0; grant_cycle = 0;
        done_count = 0; done_cycle = 0; beat_count = 0; last_beat_idx = 0;
        hold_valid = 1'b0;
    endtask

    // One clock: drive splitter/slave/requesters at negedge, observe 1 ns later.
    task automatic step();
        logic [31:0] c;
        @(negedge clk);
        cyc++;
        if (pend_xfer) begin
            sp_addr = split_address;
            sp_rem  = split_length;
        end
        if (pend_burst) begin
            c = chunk_of(sp_addr, sp_rem);
            sp_addr = sp_addr + c;
            sp_rem  = sp_rem - c;
        end
        c = chunk_of(sp_addr, sp_rem);
        split_axaddr = sp_addr;
        split_axlen  = 8'((c >> 2) - 32'd1);
        split_last   = (c == sp_rem);
        req_valid    = want_valid;
        if (m_axi_arvalid) begin
            if (ar_wait > 0) begin
                m_axi_arready = 1'b0;
                ar_wait--;
            end else begin
                m_axi_arready = 1'b1;
            end
        end else begin
            m_axi_arready = 1'b0;
        end
        if (r_idx < r_total) begin
            m_axi_rvalid = 1'b1;
            m_axi_rlast  = (early_last >= 0) ? (r_idx == early_last) : (r_idx == r_total - 1);
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
        end
        #1;
        if (|req_ready) begin
            if (grant_count < 8) grant_log[grant_count] = req_ready[1] ? 1 : 0;
            grant_count++;
            grant_cycle = cyc;
            want_valid = want_valid & ~(req_ready & drop_mask);
            if (grant_limit > 0 && grant_count >= grant_limit) want_valid = '0;
        end
        pend_xfer  = split_transfer_start;
        pend_burst = split_burst_start;
        if (split_transfer_start) xfer_cnt++;
        if (split_burst_start) begin
            burst_cnt++;
            if (!(m_axi_arvalid && m_axi_arready)) bad_burst++;
        end
        if (m_axi_rvalid && m_axi_rready) begin
            beat_count++;
            if (m_axi_rlast) last_beat_idx = beat_count;
            r_idx++;
        end
        if (m_axi_arvalid) begin
            arvalid_cycles++;
            if (hold_valid && (m_axi_araddr !== hold_addr || m_axi_arlen !== hold_len)) stall_bad++;
            hold_valid = 1'b1;
            hold_addr  = m_axi_araddr;
            hold_len   = m_axi_arlen;
            if (m_axi_arready) begin
                if (ar_count < 8) begin
                    ar_addr_log[ar_count] = m_axi_araddr;
                    ar_len_log[ar_count]  = m_axi_arlen;
                end
                ar_count++;
                hold_valid = 1'b0;
                r_total = int'(m_axi_arlen) + 1;
                r_idx   = 0;
                ar_wait = ar_stall_cfg;
            end
        end
        if (|req_done) begin
            if (done_count < 8) begin
                done_log[done_count]   = req_done;
                done_owner[done_count] = int'(owner);
            end
            done_count++;
            done_cycle = cyc;
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (done_count < target && n < 300) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 64'(done_count >= target), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_len = '0;
        split_axaddr = '0; split_axlen = '0; split_last = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        clear_logs();

        // Reset values
        step(); step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_rready", 64'(m_axi_rready), 64'd0);
        check("rst_split_addr", 64'(split_address), 64'd0);
        check("rst_split_len", 64'(split_length), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_req_done", 64'(req_done), 64'd0);
        rst = 1'b0;
        step();

        // Single aligned read: 16 bytes at 0x100
        clear_logs();
        req_addr[31:0] = 32'h100; req_len[31:0] = 32'd16;
        drop_mask = '1; want_valid = 2'b01;
        wait_done(1, "aligned");
        check("aligned_grant", 64'(grant_log[0]), 64'd0);
        check("aligned_ar_count", 64'(ar_count), 64'd1);
        check("aligned_araddr", 64'(ar_addr_log[0]), 64'h100);
        check("aligned_arlen", 64'(ar_len_log[0]), 64'd3);
        check("aligned_beats", 64'(beat_count), 64'd4);
        check("aligned_rlast_beat", 64'(last_beat_idx), 64'd4);
        check("aligned_done", 64'(done_log[0]), 64'b01);
        check("aligned_err", 64'(err), 64'd0);
        check("aligned_burst_starts", 64'(burst_cnt), 64'd1);
        check("aligned_split_len", 64'(split_length), 64'd16);
        check("aligned_busy_after", 64'(busy), 64'd0);

        // 4 KB crossing: 0x40 bytes at 0xFF0
        clear_logs();
        req_addr[31:0] = 32'hFF0; req_len[31:0] = 32'h40;
        want_valid = 2'b01;
        wait_done(1, "cross4k");
        check("cross4k_ar_count", 64'(ar_count), 64'd2);
        check("cross4k_araddr0", 64'(ar_addr_log[0]), 64'hFF0);
        check("cross4k_arlen0", 64'(ar_len_log[0]), 64'd3);
        check("cross4k_araddr1", 64'(ar_addr_log[1]), 64'h1000);
        check("cross4k_arlen1", 64'(ar_len_log[1]), 64'd11);
        check("cross4k_burst_starts", 64'(burst_cnt), 64'd2);
        check("cross4k_bad_burst", 64'(bad_burst), 64'd0);
        check("cross4k_beats", 64'(beat_count), 64'd16);
        check("cross4k_done_count", 64'(done_count), 64'd1);
        check("cross4k_err", 64'(err), 64'd0);

        // arready stalled 5 cycles on req1
        clear_logs();
        req_addr[63:32] = 32'h200; req_len[63:32] = 32'd8;
        ar_stall_cfg = 5; ar_wait = 5;
        want_valid = 2'b10;
        wait_done(1, "stall");
        ar_stall_cfg = 0; ar_wait = 0;
        check("stall_grant", 64'(grant_log[0]), 64'd1);
        check("stall_arvalid_cycles", 64'(arvalid_cycles), 64'd6);
        check("stall_unstable", 64'(stall_bad), 64'd0);
        check("stall_bad_burst", 64'(bad_burst), 64'd0);
        check("stall_burst_starts", 64'(burst_cnt), 64'd1);
        check("stall_araddr", 64'(ar_addr_log[0]), 64'h200);
        check("stall_arlen", 64'(ar_len_log[0]), 64'd1);
        check("stall_done", 64'(done_log[0]), 64'b10);

        // Zero length on req1
        clear_logs();
        req_addr[63:32] = 32'h300; req_len[63:32] = 32'd0;
        want_valid = 2'b10;
        wait_done(1, "zero");
        check("zero_done", 64'(done_log[0]), 64'b10);
        check("zero_latency", 64'(done_cycle - grant_cycle), 64'd2);
        check("zero_ar_count", 64'(ar_count), 64'd0);
        check("zero_xfer_start", 64'(xfer_cnt), 64'd0);

        // Arbitration with both requesters held valid
        clear_logs();
        req_addr[31:0] = 32'h600; req_len[31:0] = 32'd4;
        req_addr[63:32] = 32'h700; req_len[63:32] = 32'd4;
        drop_mask = '0; grant_limit = 4; want_valid = 2'b11;
        wait_done(4, "arb");
        grant_limit = 0; drop_mask = '1;
        check("arb_grant_count", 64'(grant_count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arb_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
            check($sformatf("arb_done%0d", i), 64'(done_log[i]), 64'(2'b01 << (i % 2)));
            check($sformatf("arb_owner%0d", i), 64'(done_owner[i]), 64'(i % 2));
        end

        // Early rlast on beat 2 of 4
        clear_logs();
        req_addr[31:0] = 32'h400; req_len[31:0] = 32'd16;
        early_last = 1;
        want_valid = 2'b01;
        wait_done(1, "early_rlast");
        early_last = -1;
        check("early_rlast_err", 64'(err), 64'd1);
        check("early_rlast_beats", 64'(beat_count), 64'd4);
        step(); step(); step();
        check("early_rlast_err_sticky", 64'(err), 64'd1);

        // Reset asserted while in DATA
        clear_logs();
        req_addr[31:0] = 32'h500; req_len[31:0] = 32'd16;
        want_valid = 2'b01;
        for (int n = 0; n < 50 && !m_axi_rready; n++) step();
        check("rstdata_reached", 64'(m_axi_rready), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rstdata_busy", 64'(busy), 64'd0);
        check("rstdata_rready", 64'(m_axi_rready), 64'd0);
        check("rstdata_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rstdata_err", 64'(err), 64'd0);
        check("rstdata_split_addr", 64'(split_address), 64'd0);
        check("rstdata_split_len", 64'(split_length), 64'd0);
        check("rstdata_owner", 64'(owner), 64'd0);
        check("rstdata_req_done", 64'(req_done), 64'd0);
        r_total = 0; r_idx = 0; pend_xfer = 1'b0; pend_burst = 1'b0;
        sp_addr = '0; sp_rem = '0; want_valid = '0;
        step(); step(); step();
        rst = 1'b0;
        step(); step(); step();
        check("rstdata_no_done", 64'(done_count), 64'd0);

        // Round-robin pointer restarts at requester 0 after reset
        clear_logs();
        req_addr[31:0] = 32'h800; req_len[31:0] = 32'd4;
        req_addr[63:32] = 32'h900; req_len[63:32] = 32'd4;
        drop_mask = '0; grant_limit = 1; want_valid = 2'b11;
        wait_done(1, "post_rst");
        check("post_rst_grant", 64'(grant_log[0]), 64'd0);
        check("post_rst_araddr", 64'(ar_addr_log[0]), 64'h800);
        check("post_rst_done", 64'(done_log[0]), 64'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
